// File: rtl/fu_cdb_arb.sv
// fu_cdb_arb
//   Writeback arbiter between the execution units and the common data bus.
//   Each FU owns a collapsing, order-preserving completion queue of DEPTH
//   entries. Every cycle up to NUM_CDB queue heads are granted, in
//   fixed-priority (RR_MODE=0) or round-robin (RR_MODE=1) scan order, and
//   broadcast on CDB ports 0..NUM_CDB-1. Branch recovery squashes queued and
//   incoming results whose branch mask hits the resolved branch; a correct
//   prediction clears that branch bit from all masks.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   fu_vld_i/fu_rdy_o     per-FU enqueue handshake (rdy = queue not full)
//   fu_wr_en_i            result writes the PRF (0: ROB done only)
//   fu_tag_i/rob_idx_i/value_i/br_mask_i   per-FU result payload, FU i at slice i
//   rob_br_*              branch recovery / correct-prediction / one-hot tag
//   cdb_*_o               per-port broadcast (vld, PRF write enable, tag, ROB idx, value)
//   fu_pend_o             per-FU queue non-empty
module fu_cdb_arb #(
   parameter int NUM_FU  = 4,
   parameter int NUM_CDB = 2,
   parameter int DEPTH   = 2,
   parameter int TAG_W   = 6,
   parameter int ROB_W   = 6,
   parameter int MASK_W  = 4,
   parameter int RR_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_FU-1:0]         fu_vld_i,
   output logic [NUM_FU-1:0]         fu_rdy_o,
   input  logic [NUM_FU-1:0]         fu_wr_en_i,
   input  logic [NUM_FU*TAG_W-1:0]   fu_tag_i,
   input  logic [NUM_FU*ROB_W-1:0]   fu_rob_idx_i,
   input  logic [NUM_FU*64-1:0]      fu_value_i,
   input  logic [NUM_FU*MASK_W-1:0]  fu_br_mask_i,
   input  logic                      rob_br_recovery_i,
   input  logic                      rob_br_pred_correct_i,
   input  logic [MASK_W-1:0]         rob_br_tag_fix_i,
   output logic [NUM_CDB-1:0]        cdb_vld_o,
   output logic [NUM_CDB-1:0]        cdb_wr_en_o,
   output logic [NUM_CDB*TAG_W-1:0]  cdb_tag_o,
   output logic [NUM_CDB*ROB_W-1:0]  cdb_rob_idx_o,
   output logic [NUM_CDB*64-1:0]     cdb_value_o,
   output logic [NUM_FU-1:0]         fu_pend_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic              wr_en;
      logic [TAG_W-1:0]  tag;
      logic [ROB_W-1:0]  rob_idx;
      logic [63:0]       value;
      logic [MASK_W-1:0] mask;
   } entry_t;

   entry_t            q       [NUM_FU][DEPTH];
   entry_t            q_nxt   [NUM_FU][DEPTH];
   logic [CNT_W-1:0]  cnt     [NUM_FU];
   logic [CNT_W-1:0]  cnt_nxt [NUM_FU];
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_nxt;
   logic [NUM_FU-1:0] grant;
   logic              any_grant;

   always_comb begin : status
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         fu_rdy_o[i]  = (cnt[i] < DEPTH_C);
         fu_pend_o[i] = (cnt[i] != '0);
      end
   end

   // Scan the registered heads; the k-th winner drives port k.
   always_comb begin : arb
      int unsigned n_gr;
      int unsigned idx;
      int unsigned last;
      grant         = '0;
      cdb_vld_o     = '0;
      cdb_wr_en_o   = '0;
      cdb_tag_o     = '0;
      cdb_rob_idx_o = '0;
      cdb_value_o   = '0;
      n_gr          = 0;
      last          = 0;
      idx           = 0;
      for (int unsigned j = 0; j < NUM_FU; j++) begin
         idx = (RR_MODE != 0) ? (32'(rr_ptr) + j) % NUM_FU : j;
         if (!rob_br_recovery_i && (cnt[idx] != '0) && (n_gr < NUM_CDB)) begin
            grant[idx]                              = 1'b1;
            cdb_vld_o[n_gr]                         = 1'b1;
            cdb_wr_en_o[n_gr]                       = q[idx][0].wr_en;
            cdb_tag_o[n_gr*TAG_W +: TAG_W]          = q[idx][0].tag;
            cdb_rob_idx_o[n_gr*ROB_W +: ROB_W]      = q[idx][0].rob_idx;
            cdb_value_o[n_gr*64 +: 64]              = q[idx][0].value;
            last                                    = idx;
            n_gr                                    = n_gr + 1;
         end
      end
      any_grant = (n_gr != 0);
      rr_nxt    = PTR_W'((last + 1) % NUM_FU);
   end

   // Rebuild each queue by copying survivors (not popped, not squashed)
   // toward slot 0 in order, then appending the accepted incoming entry.
   always_comb begin : q_update
      int unsigned n;
      entry_t      ent;
      logic        keep;
      logic        push;
      n    = 0;
      ent  = '0;
      keep = 1'b0;
      push = 1'b0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         n = 0;
         for (int unsigned s = 0; s < DEPTH; s++) begin
            q_nxt[i][s] = '0;
         end
         for (int unsigned s = 0; s < DEPTH; s++) begin
            ent = q[i][s];
            if (rob_br_pred_correct_i) begin
               ent.mask = ent.mask & ~rob_br_tag_fix_i;
            end
            keep = (s < 32'(cnt[i])) && !(grant[i] && (s == 0)) &&
                   !(rob_br_recovery_i && ((q[i][s].mask & rob_br_tag_fix_i) != '0));
            if (keep) begin
               q_nxt[i][n] = ent;
               n           = n + 1;
            end
         end
         ent = {fu_wr_en_i[i], fu_tag_i[i*TAG_W +: TAG_W], fu_rob_idx_i[i*ROB_W +: ROB_W],
                fu_value_i[i*64 +: 64], fu_br_mask_i[i*MASK_W +: MASK_W]};
         push = fu_vld_i[i] && fu_rdy_o[i] &&
                !(rob_br_recovery_i && ((ent.mask & rob_br_tag_fix_i) != '0));
         if (rob_br_pred_correct_i) begin
            ent.mask = ent.mask & ~rob_br_tag_fix_i;
         end
         if (push && (n < DEPTH)) begin
            q_nxt[i][n] = ent;
            n           = n + 1;
         end
         cnt_nxt[i] = CNT_W'(n);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            cnt[i] <= '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
               q[i][s] <= '0;
            end
         end
         rr_ptr <= '0;
      end else begin
         q   <= q_nxt;
         cnt <= cnt_nxt;
         if (any_grant) begin
            rr_ptr <= rr_nxt;
         end
      end
   end

   ap_rec_pc_excl: assert property (@(posedge clk) disable iff (rst)
      !(rob_br_recovery_i && rob_br_pred_correct_i));

   ap_vld_needs_rdy: assert property (@(posedge clk) disable iff (rst)
      ((fu_vld_i & ~fu_rdy_o) == '0));

endmodule
